uart_rx_fifo: RTL and testbench

- Oversampling UART receiver with a small first-word-fall-through byte FIFO.
- Sits directly upstream of the peripheral's UART receive register.
  - Deserialises the raw rxd pin into bytes.
  - Buffers bytes so the CPU can drain them at its own pace without losing back-to-back frames.
- Format is fixed: 8N1, LSB first, one stop bit.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/byte_fifo.sv | 84 ++++++++
 rtl/uart_rx_fifo.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// baud-tick divisor used by both receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int div_calc(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO; the head entry is held in a register so
// o_rdata is valid whenever o_empty is low.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [7:0]               i_wdata,
    input  logic                     i_pop,
    output logic [7:0]               o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_head;

    logic          w_do_pop;
    logic          w_do_push;
    logic [AW-1:0] w_rptr_nxt;
    logic [AW:0]   w_count_nxt;
    logic [7:0]    w_head_nxt;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CNT_MAX);
    assign o_count    = r_count;
    assign o_rdata    = r_head;

    // A pop on a full FIFO frees the slot, so a simultaneous push is accepted.
    assign w_do_pop   = i_pop & ~o_empty;
    assign w_do_push  = i_push & (~o_full | w_do_pop);
    assign w_rptr_nxt = w_do_pop ? (r_rptr + PTR_ONE) : r_rptr;

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (w_do_pop && !w_do_push) begin
            w_count_nxt = r_count - CNT_ONE;
        end

        // The pushed byte becomes the head only when it lands in the slot
        // the read pointer will point at next.
        w_head_nxt = r_mem[w_rptr_nxt];
        if (w_count_nxt == '0) begin
            w_head_nxt = '0;
        end else if (w_do_push && (r_wptr == w_rptr_nxt)) begin
            w_head_nxt = i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1 UART receiver feeding a small FWFT byte FIFO, with sticky
// frame-error and overrun flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DEPTH      = 4
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     rxd,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [7:0]               rd_data,
    output logic                     rx_valid,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic                     frame_err,
    output logic                     overrun
);

    localparam int DIV   = div_calc(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [SC_W-1:0]  SC_HALF  = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
    localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    logic                 r_rx_meta;
    logic                 r_rxs;
    logic [DIV_W-1:0]     r_div_cnt;
    rx_state_t            r_state;
    logic [SC_W-1:0]      r_scnt;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_push;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic                 w_tick;
    logic                 w_restart;
    rx_state_t            w_state_nxt;
    logic [SC_W-1:0]      w_scnt_nxt;
    logic [BIT_W-1:0]     w_bit_nxt;
    logic [DATA_BITS-1:0] w_shreg_nxt;
    logic                 w_push_nxt;
    logic                 w_ferr_set;
    logic                 w_ovr_set;
    logic                 w_full;
    logic                 w_empty;

    // Preset high so a reset never looks like a start edge.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rxd;
            r_rxs     <= r_rx_meta;
        end
    end

    assign w_tick    = (r_div_cnt == DIV_LAST);
    assign w_restart = (r_state == IDLE) && !r_rxs;

    always_ff @(posedge sysclk) begin
        if (reset || w_restart || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_ONE;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scnt_nxt  = r_scnt;
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        w_push_nxt  = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rxs) begin
                    w_state_nxt = START;
                    w_scnt_nxt  = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_scnt == SC_HALF) begin
                        w_scnt_nxt = '0;
                        if (r_rxs) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = DATA;
                            w_bit_nxt   = '0;
                        end
                    end else begin
                        w_scnt_nxt = r_scnt + SC_ONE;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_scnt == SC_LAST) begin
                        w_shreg_nxt[r_bit] = r_rxs;
                        w_scnt_nxt         = '0;
                        if (r_bit == BIT_LAST) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_bit_nxt = r_bit + BIT_ONE;
                        end
                    end else begin
                        w_scnt_nxt = r_scnt + SC_ONE;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_scnt == SC_LAST) begin
                        w_scnt_nxt = '0;
                        if (r_rxs) begin
                            w_push_nxt  = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_ferr_set  = 1'b1;
                            w_state_nxt = BREAK;
                        end
                    end else begin
                        w_scnt_nxt = r_scnt + SC_ONE;
                    end
                end
            end
            BREAK: begin
                if (r_rxs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state <= IDLE;
            r_scnt  <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_push  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_scnt  <= w_scnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shreg <= w_shreg_nxt;
            r_push  <= w_push_nxt;
        end
    end

    // When full, the FIFO is non-empty, so rd_en alone decides whether the slot frees up.
    assign w_ovr_set = r_push & w_full & ~rd_en;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr_set | (r_frame_err & ~clr_err);
            r_overrun   <= w_ovr_set | (r_overrun & ~clr_err);
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (sysclk),
        .i_rst   (reset),
        .i_push  (r_push),
        .i_wdata (r_shreg),
        .i_pop   (rd_en),
        .o_rdata (rd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (rx_count)
    );

    assign rx_valid  = ~w_empty;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo against a queue-based model
// of the received byte stream and error flags.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CLK_HZ = 6400000;
    localparam int BAUD   = 100000;
    localparam int OS     = 16;
    localparam int DEPTH  = 4;
    localparam int BITC   = CLK_HZ / BAUD;
    localparam int PUSH_C = 611;

    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;

    always #5 sysclk = ~sysclk;

    uart_rx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .DEPTH      (DEPTH)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .rxd       (rxd),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .rx_valid  (rx_valid),
        .rx_count  (rx_count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        @(negedge sysclk);
        chk({tag, "_valid"}, {7'd0, rx_valid}, {7'd0, q.size() != 0});
        chk({tag, "_count"}, {5'd0, rx_count}, 8'(q.size()));
        if (q.size() != 0) chk({tag, "_data"}, rd_data, q[0]);
        chk({tag, "_ferr"}, {7'd0, frame_err}, {7'd0, m_ferr});
        chk({tag, "_ovr"}, {7'd0, overrun}, {7'd0, m_ovr});
    endtask

    function automatic void m_good(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovr = 1'b1;
    endfunction

    function automatic void m_pop();
        if (q.size() != 0) void'(q.pop_front());
    endfunction

    // Drives one frame; stop_low extends a low stop bit by whole bit times
    // followed by one idle bit, pop_at pulses rd_en at that cycle offset.
    task automatic send_frame(input logic [7:0] b, input int stop_low, input int pop_at);
        int nbits;
        int i;
        nbits = (stop_low > 0) ? 10 + stop_low : 10;
        @(posedge sysclk);
        for (int c = 0; c < nbits * BITC; c++) begin
            i = c / BITC;
            #1;
            if (i == 0) rxd = 1'b0;
            else if (i <= 8) rxd = b[i-1];
            else rxd = (i < 9 + stop_low) ? 1'b0 : 1'b1;
            rd_en = (c == pop_at);
            @(posedge sysclk);
        end
        #1;
        rd_en = 1'b0;
        rxd   = 1'b1;
    endtask

    task automatic pop_one();
        @(posedge sysclk);
        #1 rd_en = 1'b1;
        @(posedge sysclk);
        #1 rd_en = 1'b0;
        m_pop();
    endtask

    task automatic pulse_clr();
        @(posedge sysclk);
        #1 clr_err = 1'b1;
        @(posedge sysclk);
        #1 clr_err = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int         pa;

        repeat (5) @(posedge sysclk);
        #1 reset = 1'b0;
        check_state("reset");
        chk("reset_rd_data", rd_data, 8'h00);

        send_frame(8'hA5, 0, -1);
        m_good(8'hA5);
        check_state("a5");
        pop_one();
        check_state("a5_pop");

        @(posedge sysclk);
        #1 rxd = 1'b0;
        repeat (20) @(posedge sysclk);
        #1 rxd = 1'b1;
        repeat (64) @(posedge sysclk);
        check_state("glitch");
        send_frame(8'h3C, 0, -1);
        m_good(8'h3C);
        check_state("3c");
        pop_one();

        send_frame(8'h55, 2, -1);
        m_ferr = 1'b1;
        check_state("stop_low");
        send_frame(8'h81, 0, -1);
        m_good(8'h81);
        check_state("81");
        pop_one();
        pulse_clr();
        check_state("clr_ferr");

        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 0, -1);
            m_good(8'(k));
        end
        check_state("overrun");
        for (int k = 0; k < 4; k++) begin
            pop_one();
            check_state("drain");
        end
        pulse_clr();
        check_state("clr_ovr");

        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            send_frame(b, 0, -1);
            m_good(b);
        end
        check_state("full");
        send_frame(8'h77, 0, PUSH_C);
        m_pop();
        m_good(8'h77);
        check_state("push_pop_full");
        for (int k = 0; k < 4; k++) begin
            check_state("drain2");
            pop_one();
        end
        check_state("drained");

        for (int k = 0; k < 8; k++) begin
            b  = 8'($urandom);
            pa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(100, 500)) : -1;
            send_frame(b, 0, pa);
            if (pa >= 0) m_pop();
            m_good(b);
            check_state("rand");
            if ($urandom_range(0, 2) == 0) begin
                pop_one();
                check_state("rand_pop");
            end
        end

        b = 8'hF0;
        @(posedge sysclk);
        for (int c = 0; c < 300; c++) begin
            #1;
            if (c < BITC) rxd = 1'b0;
            else rxd = b[c / BITC - 1];
            @(posedge sysclk);
        end
        #1 reset = 1'b1;
        rxd = 1'b1;
        repeat (3) @(posedge sysclk);
        #1 reset = 1'b0;
        q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check_state("mid_reset");
        chk("mid_reset_rd_data", rd_data, 8'h00);
        repeat (700) @(posedge sysclk);
        check_state("no_push");
        send_frame(8'h0F, 0, -1);
        m_good(8'h0F);
        check_state("0f");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
